// File: rtl/sad_accum_pkg.sv
// Shared types and width helpers for the SAD accumulator block.
// Widths derived from module parameters go through the functions below.
package sad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int row_sum_w(input int pix_w, input int pix_per_row);
        return pix_w + clog2(pix_per_row);
    endfunction

    function automatic int cnt_w(input int rows);
        return (clog2(rows + 1) < 1) ? 1 : clog2(rows + 1);
    endfunction

    function automatic int idx_w(input int num_cand);
        return (clog2(num_cand) < 1) ? 1 : clog2(num_cand);
    endfunction

    localparam int DEF_NUM_CAND    = 5;
    localparam int DEF_PIX_PER_ROW = 6;
    localparam int DEF_PIX_W       = 8;
    localparam int DEF_ROWS        = 6;
    localparam int DEF_SAD_W       = 14;

    localparam int ROW_SUM_W = row_sum_w(DEF_PIX_W, DEF_PIX_PER_ROW);
    localparam int CNT_W     = cnt_w(DEF_ROWS);
    localparam int IDX_W     = idx_w(DEF_NUM_CAND);

endpackage

// File: rtl/sad_accum_if.sv
// Row-in / result-out handshake bundle of the SAD accumulator.
// master = row producer and result consumer, slave = sad_accum.
interface sad_accum_if #(
    parameter int NUM_CAND    = 5,
    parameter int PIX_PER_ROW = 6,
    parameter int PIX_W       = 8,
    parameter int SAD_W       = 14
);
    import sad_pkg::*;

    localparam int IDX_W = idx_w(NUM_CAND);

    logic                                  in_valid;
    logic                                  in_ready;
    logic [NUM_CAND*PIX_PER_ROW*PIX_W-1:0] diff_vec;
    logic                                  abort;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_CAND*SAD_W-1:0]             sad_vector;
    logic [IDX_W-1:0]                      best_idx;
    logic [SAD_W-1:0]                      best_sad;

    modport master (
        output in_valid, diff_vec, abort, out_ready,
        input  in_ready, out_valid, sad_vector, best_idx, best_sad
    );

    modport slave (
        input  in_valid, diff_vec, abort, out_ready,
        output in_ready, out_valid, sad_vector, best_idx, best_sad
    );

endinterface

// File: rtl/sad_accum_row_sum.sv
// Purpose: unsigned sum of one candidate's row of absolute differences.
// Latency: combinational. Backpressure: none, pure datapath.
module sad_row_sum
    import sad_pkg::*;
#(
    parameter int PIX_PER_ROW = 6,
    parameter int PIX_W       = 8,
    parameter int SUM_W       = row_sum_w(PIX_W, PIX_PER_ROW)
) (
    input  logic [PIX_PER_ROW*PIX_W-1:0] pix,
    output logic [SUM_W-1:0]             sum
);

    always_comb begin
        sum = '0;
        for (int p = 0; p < PIX_PER_ROW; p++) begin
            sum = sum + SUM_W'(pix[p*PIX_W +: PIX_W]);
        end
    end

endmodule

// File: rtl/sad_accum.sv
// Purpose: accumulate ROWS rows of abs diffs into per-candidate SADs plus best pick (SAD_ACCUM_BEST_SEL_EN).
// Latency: result valid the cycle after the ROWS-th row is accepted.
// Backpressure: result held until out_ready; while held, in_ready follows out_ready.
module sad_accum
    import sad_pkg::*;
#(
    parameter int NUM_CAND    = 5,
    parameter int PIX_PER_ROW = 6,
    parameter int PIX_W       = 8,
    parameter int ROWS        = 6,
    parameter int SAD_W       = 14
) (
    input  logic        clk,
    input  logic        rst_n,
    sad_accum_if.slave  bus
);

    localparam int RS_W    = row_sum_w(PIX_W, PIX_PER_ROW);
    localparam int CNT_W_L = cnt_w(ROWS);
    localparam int IDX_W_L = idx_w(NUM_CAND);
    localparam int ROW_W   = PIX_PER_ROW * PIX_W;

    state_e                            state_q, state_d;
    logic [CNT_W_L-1:0]                row_cnt_q, row_cnt_d;
    logic [NUM_CAND-1:0][SAD_W-1:0]    acc_q, acc_final, sad_q;
    logic [NUM_CAND-1:0][RS_W-1:0]     row_sum;
    logic [IDX_W_L-1:0]                best_idx_q, best_idx_d;
    logic [SAD_W-1:0]                  best_sad_q, best_sad_d;
    logic                              in_ready_c;
    logic                              acc_we;
    logic                              acc_first;
    logic                              done_load;

    for (genvar c = 0; c < NUM_CAND; c++) begin : g_row
        sad_row_sum #(
            .PIX_PER_ROW (PIX_PER_ROW),
            .PIX_W       (PIX_W),
            .SUM_W       (RS_W)
        ) u_row_sum (
            .pix (bus.diff_vec[c*ROW_W +: ROW_W]),
            .sum (row_sum[c])
        );
    end

    // The first row of a block overwrites instead of adding, so no clear cycle is needed.
    always_comb begin
        acc_final = '0;
        for (int c = 0; c < NUM_CAND; c++) begin
            acc_final[c] = acc_first ? SAD_W'(row_sum[c])
                                     : acc_q[c] + SAD_W'(row_sum[c]);
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        in_ready_c = 1'b0;
        acc_we     = 1'b0;
        acc_first  = 1'b0;
        done_load  = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_c = 1'b1;
                if (bus.abort) begin
                    row_cnt_d = '0;
                end else if (bus.in_valid) begin
                    acc_we    = 1'b1;
                    acc_first = 1'b1;
                    if (ROWS == 1) begin
                        state_d   = DONE;
                        done_load = 1'b1;
                        row_cnt_d = '0;
                    end else begin
                        state_d   = ACCUM;
                        row_cnt_d = CNT_W_L'(1);
                    end
                end
            end
            ACCUM: begin
                in_ready_c = 1'b1;
                if (bus.abort) begin
                    state_d   = IDLE;
                    row_cnt_d = '0;
                end else if (bus.in_valid) begin
                    acc_we    = 1'b1;
                    row_cnt_d = row_cnt_q + CNT_W_L'(1);
                    if (row_cnt_q == CNT_W_L'(ROWS - 1)) begin
                        state_d   = DONE;
                        done_load = 1'b1;
                        row_cnt_d = '0;
                    end
                end
            end
            DONE: begin
                // abort is deliberately not looked at: a finished result always drains.
                in_ready_c = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        acc_we    = 1'b1;
                        acc_first = 1'b1;
                        if (ROWS == 1) begin
                            done_load = 1'b1;
                            row_cnt_d = '0;
                        end else begin
                            state_d   = ACCUM;
                            row_cnt_d = CNT_W_L'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                row_cnt_d = '0;
            end
        endcase
    end

`ifdef SAD_ACCUM_BEST_SEL_EN
    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx_d = '0;
        best_sad_d = acc_final[0];
        for (int c = 1; c < NUM_CAND; c++) begin
            if (acc_final[c] < best_sad_d) begin
                best_sad_d = acc_final[c];
                best_idx_d = IDX_W_L'(c);
            end
        end
    end
`else
    assign best_idx_d = '0;
    assign best_sad_d = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            acc_q      <= '0;
            sad_q      <= '0;
            best_idx_q <= '0;
            best_sad_q <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            if (acc_we) acc_q <= acc_final;
            if (done_load) begin
                sad_q      <= acc_final;
                best_idx_q <= best_idx_d;
                best_sad_q <= best_sad_d;
            end
        end
    end

    assign bus.in_ready   = in_ready_c;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.sad_vector = sad_q;
    assign bus.best_idx   = best_idx_q;
    assign bus.best_sad   = best_sad_q;

endmodule

// File: tb/tb_sad_accum.sv
// Bench for sad_accum: a 14-bit and an 8-bit (wrapping) instance share one stimulus
// stream and are checked every cycle against a row-counting reference model.
module tb_sad_accum;

    localparam int NC  = 5;
    localparam int PPR = 6;
    localparam int PW  = 8;
    localparam int RW  = 6;
    localparam int SW1 = 14;
    localparam int SW2 = 8;
    localparam int DW  = NC * PPR * PW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          abort;
    logic          out_ready;
    logic [DW-1:0] diff_vec;
    bit            chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    // reference model state
    int acc_m [NC];
    int res_m [NC];
    int nrows = 0;
    bit pend  = 1'b0;

    always #5 clk = ~clk;

    sad_accum_if #(.NUM_CAND(NC), .PIX_PER_ROW(PPR), .PIX_W(PW), .SAD_W(SW1)) bus14 ();
    sad_accum_if #(.NUM_CAND(NC), .PIX_PER_ROW(PPR), .PIX_W(PW), .SAD_W(SW2)) bus8 ();

    assign bus14.in_valid  = in_valid;
    assign bus14.diff_vec  = diff_vec;
    assign bus14.abort     = abort;
    assign bus14.out_ready = out_ready;
    assign bus8.in_valid   = in_valid;
    assign bus8.diff_vec   = diff_vec;
    assign bus8.abort      = abort;
    assign bus8.out_ready  = out_ready;

    sad_accum #(.NUM_CAND(NC), .PIX_PER_ROW(PPR), .PIX_W(PW), .ROWS(RW), .SAD_W(SW1)) u_dut14 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus14)
    );

    sad_accum #(.NUM_CAND(NC), .PIX_PER_ROW(PPR), .PIX_W(PW), .ROWS(RW), .SAD_W(SW2)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int row_sum_of(input logic [DW-1:0] v, input int c);
        int s;
        s = 0;
        for (int p = 0; p < PPR; p++) s += int'(v[(c*PPR+p)*PW +: PW]);
        return s;
    endfunction

    function automatic int wrap(input int v, input int w);
        return v % (1 << w);
    endfunction

    function automatic void exp_best(input int w, output int idx, output int val);
        idx = 0;
        val = wrap(res_m[0], w);
        for (int c = 1; c < NC; c++) begin
            if (wrap(res_m[c], w) < val) begin
                val = wrap(res_m[c], w);
                idx = c;
            end
        end
`ifndef SAD_ACCUM_BEST_SEL_EN
        idx = 0;
        val = 0;
`endif
    endfunction

    function automatic logic [DW-1:0] fill(input logic [7:0] b);
        logic [DW-1:0] v;
        for (int i = 0; i < NC*PPR; i++) v[i*PW +: PW] = b;
        return v;
    endfunction

    function automatic logic [DW-1:0] rnd_vec();
        logic [DW-1:0] v;
        for (int i = 0; i < NC*PPR; i++) v[i*PW +: PW] = PW'($urandom);
        return v;
    endfunction

    // Model: count accepted rows; the ROWS-th row publishes the block sum.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NC; c++) begin
                acc_m[c] = 0;
                res_m[c] = 0;
            end
            nrows = 0;
            pend  = 1'b0;
        end else begin
            bit was;
            bit rdy;
            was = pend;
            rdy = !pend || out_ready;
            if (pend && out_ready) pend = 1'b0;
            if (in_valid && rdy && (was || !abort)) begin
                for (int c = 0; c < NC; c++) begin
                    acc_m[c] = (nrows == 0) ? row_sum_of(diff_vec, c)
                                            : acc_m[c] + row_sum_of(diff_vec, c);
                end
                nrows++;
                if (nrows == RW) begin
                    res_m = acc_m;
                    pend  = 1'b1;
                    nrows = 0;
                end
            end else if (abort && !was) begin
                nrows = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            int bi;
            int bv;
            chk("in_ready14", bus14.in_ready, !pend || out_ready);
            chk("in_ready8", bus8.in_ready, !pend || out_ready);
            chk("out_valid14", bus14.out_valid, pend);
            chk("out_valid8", bus8.out_valid, pend);
            for (int c = 0; c < NC; c++) begin
                chk($sformatf("sad14[%0d]", c), bus14.sad_vector[c*SW1 +: SW1], wrap(res_m[c], SW1));
                chk($sformatf("sad8[%0d]", c), bus8.sad_vector[c*SW2 +: SW2], wrap(res_m[c], SW2));
            end
            exp_best(SW1, bi, bv);
            chk("best_idx14", bus14.best_idx, bi);
            chk("best_sad14", bus14.best_sad, bv);
            exp_best(SW2, bi, bv);
            chk("best_idx8", bus8.best_idx, bi);
            chk("best_sad8", bus8.best_sad, bv);
        end
    end

    // call at posedge+1; leaves in_valid low at the next posedge+1
    task automatic send_row(input logic [DW-1:0] v);
        in_valid = 1'b1;
        diff_vec = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pin_all(input string tag, input int v14, input int v8);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s_sad14[%0d]", tag, c), bus14.sad_vector[c*SW1 +: SW1], v14);
            chk($sformatf("%s_sad8[%0d]", tag, c), bus8.sad_vector[c*SW2 +: SW2], v8);
        end
    endtask

    initial begin
        logic [DW-1:0] v;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        diff_vec  = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("rst_out_valid", bus14.out_valid, 0);
        chk("rst_sad", bus14.sad_vector, 0);
        chk("rst_best_idx", bus14.best_idx, 0);
        chk("rst_best_sad", bus14.best_sad, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // all ones: every SAD 36, tie -> index 0
        repeat (RW) send_row(fill(8'h01));
        @(negedge clk);
        chk("t1_out_valid", bus14.out_valid, 1);
        pin_all("t1", 36, 36);
        chk("t1_model", res_m[2], 36);
`ifdef SAD_ACCUM_BEST_SEL_EN
        chk("t1_best_idx", bus14.best_idx, 0);
        chk("t1_best_sad", bus14.best_sad, 36);
`else
        chk("t1_best_idx", bus14.best_idx, 0);
        chk("t1_best_sad", bus14.best_sad, 0);
`endif
        @(posedge clk);
        #1;

        // candidate 3 zero, others saturated: 9180, wraps to 220 in 8 bits
        v = fill(8'hFF);
        v[3*PPR*PW +: PPR*PW] = '0;
        repeat (RW) send_row(v);
        @(negedge clk);
        chk("t2_sad14_c3", bus14.sad_vector[3*SW1 +: SW1], 0);
        chk("t2_sad14_c0", bus14.sad_vector[0 +: SW1], 9180);
        chk("t2_sad8_c4", bus8.sad_vector[4*SW2 +: SW2], 220);
        chk("t2_model", res_m[1], 9180);
`ifdef SAD_ACCUM_BEST_SEL_EN
        chk("t2_best_idx", bus14.best_idx, 3);
        chk("t2_best_sad", bus14.best_sad, 0);
`else
        chk("t2_best_idx", bus14.best_idx, 0);
        chk("t2_best_sad", bus14.best_sad, 0);
`endif
        @(posedge clk);
        #1;

        // backpressure: result held 5 cycles, then next block starts on the consume cycle
        out_ready = 1'b0;
        repeat (RW) send_row(rnd_vec());
        repeat (5) @(negedge clk);
        chk("t3_held_valid", bus14.out_valid, 1);
        chk("t3_held_ready", bus14.in_ready, 0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (RW) send_row(rnd_vec());
        @(negedge clk);
        chk("t3_second_valid", bus14.out_valid, 1);
        @(posedge clk);
        #1;

        // abort after 3 rows, with a row presented in the abort cycle
        repeat (3) send_row(rnd_vec());
        abort    = 1'b1;
        in_valid = 1'b1;
        diff_vec = rnd_vec();
        @(posedge clk);
        #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        repeat (RW) send_row(fill(8'h02));
        @(negedge clk);
        chk("t4_out_valid", bus14.out_valid, 1);
        pin_all("t4", 72, 72);
        chk("t4_model", res_m[4], 72);
        @(posedge clk);
        #1;

        // asynchronous reset mid-block
        repeat (4) send_row(rnd_vec());
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus14.out_valid, 0);
        chk("t5_rst_sad14", bus14.sad_vector, 0);
        chk("t5_rst_sad8", bus8.sad_vector, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (RW) send_row(fill(8'h03));
        @(negedge clk);
        pin_all("t5", 108, 108);
        @(posedge clk);
        #1;

        // random traffic, backpressure and aborts
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            abort     = ($urandom % 16) == 0;
            diff_vec  = rnd_vec();
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sad_accum.md
Name: sad_accum

Overview:
- Parametrised, sequential successor to the combinational per-row SAD summer in the sub-pixel motion-estimation datapath.
- Accepts one row of absolute differences per candidate per handshake. Accumulates ROWS rows into one SAD per candidate.
- Presents the completed SAD vector, plus best-candidate index and value, on a valid/ready output to the ME decision stage.

Parameters:
- NUM_CAND, 5, number of candidate positions per block
- PIX_PER_ROW, 6, absolute differences per candidate per row
- PIX_W, 8, width of one absolute difference
- ROWS, 6, rows accumulated per block; must be >= 1
- SAD_W, 14, accumulator width per candidate; full range requires SAD_W >= PIX_W + clog2(PIX_PER_ROW*ROWS)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  diff_vec holds a valid row
- in_ready  out  1  block accepts a row this cycle
- diff_vec  in  NUM_CAND*PIX_PER_ROW*PIX_W  candidate c, pixel p at bits [(c*PIX_PER_ROW+p)*PIX_W +: PIX_W]
- abort  in  1  synchronous discard of the partial block
- out_valid  out  1  sad_vector, best_idx and best_sad are valid
- out_ready  in  1  downstream accepts the result
- sad_vector  out  NUM_CAND*SAD_W  candidate c at [c*SAD_W +: SAD_W]
- best_idx  out  max(1,clog2(NUM_CAND))  index of the minimum SAD
- best_sad  out  SAD_W  minimum SAD value

Behaviour:
- Clocking and reset: single clock domain. Asynchronous, active-low reset (rst_n).
- Reset values: state=IDLE, row_cnt=0, accumulators=0, out_valid=0, sad_vector=0, best_idx=0, best_sad=0.
- Row sum: each candidate's row sum is the unsigned sum of PIX_PER_ROW values, width PIX_W+clog2(PIX_PER_ROW), zero-extended to SAD_W. Accumulation is modulo 2^SAD_W; no saturation.
- Row accept: a row is accepted when in_valid && in_ready.
- States:
  - IDLE: in_ready=1. On accept: acc = row sum, row_cnt=1, go to ACCUM. If ROWS==1, go straight to DONE.
  - ACCUM: in_ready=1. On accept: acc += row sum, row_cnt++. When the accepted row is row ROWS, go to DONE.
  - DONE: out_valid=1. Outputs are stable until out_ready.
    - in_ready = out_ready, so the first row of the next block can be taken in the same cycle the result is consumed.
    - out_ready && !in_valid -> IDLE.
    - out_ready && in_valid -> acc = new row sum, row_cnt=1, go to ACCUM (or stay in DONE if ROWS==1).
- Latency: out_valid rises the cycle after the ROWS-th row is accepted. The result registers (sad_vector, best_idx, best_sad) load in that same edge.
- Best selection: computed combinationally from the final accumulated values and registered together with them. Ties resolve to the lowest index.
- abort:
  - In IDLE or ACCUM: go to IDLE, row_cnt=0. Any row presented in the same cycle is dropped.
  - In DONE: ignored; a completed result is never discarded.
- Reset mid-block: all partial state is lost and no result is emitted.
- in_valid is ignored while in_ready=0. diff_vec is don't-care when not accepted.

Optional Feature:
- SAD_ACCUM_BEST_SEL_EN
  - Defined: best_idx and best_sad are computed as above.
  - Undefined: the comparator tree is not built; best_idx and best_sad are tied to 0. sad_vector and handshake timing are unchanged.

Decomposition:
- Package sad_pkg holds:
  - state enum (IDLE, ACCUM, DONE)
  - clog2 function
  - derived constants: ROW_SUM_W, CNT_W = clog2(ROWS+1), IDX_W
- Sub-module sad_row_sum: a combinational adder of PIX_PER_ROW x PIX_W inputs producing ROW_SUM_W. Instantiated once per candidate with a generate loop.

Test Plan:
- Defaults: 6 rows, all diffs 0x01, out_ready=1 -> out_valid one cycle after 6th row; every SAD=36; best_idx=0 (tie); best_sad=36.
- Defaults: candidate 3 diffs=0x00, all others 0xFF, 6 rows -> SAD[3]=0, others=9180; best_idx=3; best_sad=0.
- out_ready held low 5 cycles after result -> out_valid and outputs held stable, in_ready=0. Then out_ready=1 with in_valid=1 -> next block row accepted the same cycle; second block result is correct, with no carry-over from the first.
- abort asserted after 3 rows, then 6 rows of 0x02 -> single result, all SAD=72; no output for the aborted block.
- rst_n pulsed low after 4 rows -> all outputs 0 immediately (asynchronous). The following full block produces a correct result.
- SAD_W=8, 6 rows of 0xFF -> each SAD = 9180 mod 256 = 220 (wrap confirmed). Rerun without SAD_ACCUM_BEST_SEL_EN -> best_idx=0 and best_sad=0 throughout.
